bin_display: RTL and testbench

Parametrised N-digit decimal display driver: accepts an unsigned binary value through a one-cycle load strobe and converts it to BCD serially, one shift-add-3 step per clock. It then drives DIGITS active-low seven-segment outputs, with optional leading-zero blanking and an overflow indication. It supersedes the fixed two-digit, per-digit-BCD display path and feeds the board HEX displays directly.

---
 rtl/bin_display_if.sv | 17 +
 rtl/bin_display.sv | 137 +++++++++++++
 tb/tb_bin_display.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bin_display_if.sv
// Load/status/segment bundle between a display client and bin_display.
// master drives the value and strobe; slave is the converter.
interface bin_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
);
  logic [WIDTH-1:0]    VALUE;
  logic                LOAD;
  logic                BLANK_LZ;
  logic                BUSY;
  logic                DONE;
  logic                OVF;
  logic [7*DIGITS-1:0] HEX;

  modport master (output VALUE, LOAD, BLANK_LZ, input BUSY, DONE, OVF, HEX);
  modport slave  (input VALUE, LOAD, BLANK_LZ, output BUSY, DONE, OVF, HEX);
endinterface

// File: rtl/bin_display.sv
// Serial binary-to-BCD converter (shift-add-3, one step per clock) driving
// DIGITS active-low seven-segment outputs with blanking and overflow dashes.
module bin_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input logic         clk,
  input logic         reset,
  bin_display_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    sh, sh_n, sh_shift;
  logic [BW-1:0]       bcd, bcd_n, adj, bcd_shift;
  logic [CW-1:0]       cnt, cnt_n;
  logic                blank, blank_n;
  logic                ovf_acc, ovf_acc_n, ovf_fin;
  logic                ovf, ovf_n;
  logic                done, done_n;
  logic [7*DIGITS-1:0] hex, hex_n, seg;
  logic [3:0]          nib;
  logic                lead;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step; the carry out of the top nibble marks overflow.
  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end
    {bcd_shift, sh_shift} = {adj, sh} << 1;
    ovf_fin = ovf_acc | adj[BW-1];
  end

  // Segment image of the post-step BCD; only latched on the final step.
  always_comb begin
    seg  = '0;
    nib  = '0;
    lead = blank;
    for (int unsigned k = DIGITS; k > 0; k--) begin
      nib = bcd_shift[4*(k-1) +: 4];
      if (ovf_fin) begin
        seg[7*(k-1) +: 7] = 7'b0111111;
      end else if (lead && nib == 4'd0 && k > 1) begin
        seg[7*(k-1) +: 7] = 7'b1111111;
      end else begin
        seg[7*(k-1) +: 7] = seg7(nib);
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bcd_n     = bcd;
    cnt_n     = cnt;
    blank_n   = blank;
    ovf_acc_n = ovf_acc;
    ovf_n     = ovf;
    hex_n     = hex;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.LOAD) begin
          state_n   = CONV;
          sh_n      = bus.VALUE;
          bcd_n     = '0;
          cnt_n     = CW'(WIDTH);
          blank_n   = bus.BLANK_LZ;
          ovf_acc_n = 1'b0;
        end
      end
      CONV: begin
        sh_n      = sh_shift;
        bcd_n     = bcd_shift;
        ovf_acc_n = ovf_fin;
        cnt_n     = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          hex_n   = seg;
          ovf_n   = ovf_fin;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      blank   <= 1'b0;
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      hex     <= {DIGITS{7'b1000000}};
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bcd     <= bcd_n;
      cnt     <= cnt_n;
      blank   <= blank_n;
      ovf_acc <= ovf_acc_n;
      ovf     <= ovf_n;
      done    <= done_n;
      hex     <= hex_n;
    end
  end

  assign bus.BUSY = (state == CONV);
  assign bus.DONE = done;
  assign bus.OVF  = ovf;
  assign bus.HEX  = hex;
endmodule

// File: tb/tb_bin_display.sv
// Bench for bin_display: 8-bit/2-digit and 10-bit/3-digit instances,
// expected results queued at load time and checked when DONE appears.
module tb_bin_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

  typedef struct {
    logic [9:0]  v;
    logic        b;
    logic [20:0] h;
    logic        o;
  } vec_t;

  typedef struct {
    logic [20:0] h;
    logic        o;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst8 = 1'b1, rst10 = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  exp_t q8[$], q10[$];

  bin_display_if #(.WIDTH(8),  .DIGITS(2)) i8 ();
  bin_display_if #(.WIDTH(10), .DIGITS(3)) i10 ();

  bin_display #(.WIDTH(8),  .DIGITS(2)) u8  (.clk(clk), .reset(rst8),  .bus(i8));
  bin_display #(.WIDTH(10), .DIGITS(3)) u10 (.clk(clk), .reset(rst10), .bus(i10));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal reference: digit values by / and %, then blanking from the top.
  function automatic void model(input int v, input bit b, input int nd,
                                output logic [20:0] h, output logic o);
    int  lim;
    int  x;
    int  d[3];
    bit  lead;
    logic [6:0] tbl[10];
    tbl = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
    lim = 1;
    for (int k = 0; k < nd; k++) lim *= 10;
    o = (v >= lim);
    x = v;
    for (int k = 0; k < 3; k++) begin
      d[k] = x % 10;
      x    = x / 10;
    end
    h    = '0;
    lead = b;
    for (int k = nd - 1; k >= 0; k--) begin
      if (o) h[7*k +: 7] = SD;
      else if (lead && d[k] == 0 && k > 0) h[7*k +: 7] = SB;
      else begin
        h[7*k +: 7] = tbl[d[k]];
        lead = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (i8.DONE) begin
      check("done_busy8", {20'd0, i8.BUSY}, 21'd0);
      if (q8.size() == 0) begin
        check("spurious_done8", {7'd0, i8.HEX}, 21'h1fffff);
      end else begin
        e = q8.pop_front();
        check("hex8", {7'd0, i8.HEX}, e.h);
        check("ovf8", {20'd0, i8.OVF}, {20'd0, e.o});
        check("latency8", 21'(cyc), 21'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (i10.DONE) begin
      check("done_busy10", {20'd0, i10.BUSY}, 21'd0);
      if (q10.size() == 0) begin
        check("spurious_done10", i10.HEX, 21'h1fffff);
      end else begin
        e = q10.pop_front();
        check("hex10", i10.HEX, e.h);
        check("ovf10", {20'd0, i10.OVF}, {20'd0, e.o});
        check("latency10", 21'(cyc), 21'(e.due));
      end
    end
  end

  // Starts at a negedge; waits (bounded) for an idle cycle, then strobes LOAD for one cycle.
  task automatic load8(input logic [9:0] v, input logic b, input logic [20:0] h,
                       input logic o, input bit push);
    int t = 0;
    while (i8.BUSY && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (i8.BUSY) check("idle_timeout8", 21'd1, 21'd0);
    i8.VALUE    = v[7:0];
    i8.BLANK_LZ = b;
    i8.LOAD     = 1'b1;
    if (push) q8.push_back('{h: h, o: o, due: cyc + 9});
    @(negedge clk);
    i8.LOAD = 1'b0;
  endtask

  task automatic load10(input logic [9:0] v, input logic b, input logic [20:0] h, input logic o);
    int t = 0;
    while (i10.BUSY && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (i10.BUSY) check("idle_timeout10", 21'd1, 21'd0);
    i10.VALUE    = v;
    i10.BLANK_LZ = b;
    i10.LOAD     = 1'b1;
    q10.push_back('{h: h, o: o, due: cyc + 11});
    @(negedge clk);
    i10.LOAD = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((q8.size() != 0 || q10.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 21'(q8.size() + q10.size()), 21'd0);
  endtask

  vec_t t8[10];
  vec_t t10[5];

  initial begin
    logic [20:0] mh;
    logic        mo;
    int          busy_n;
    int          v;

    i8.LOAD = 1'b0;  i8.VALUE = '0;  i8.BLANK_LZ = 1'b0;
    i10.LOAD = 1'b0; i10.VALUE = '0; i10.BLANK_LZ = 1'b0;

    t8[0] = '{10'd0,   1'b1, {7'd0, SB, S0}, 1'b0};
    t8[1] = '{10'd99,  1'b0, {7'd0, S9, S9}, 1'b0};
    t8[2] = '{10'd200, 1'b0, {7'd0, SD, SD}, 1'b1};
    t8[3] = '{10'd7,   1'b1, {7'd0, SB, S7}, 1'b0};
    t8[4] = '{10'd45,  1'b0, {7'd0, S4, S5}, 1'b0};
    t8[5] = '{10'd100, 1'b1, {7'd0, SD, SD}, 1'b1};
    t8[6] = '{10'd10,  1'b1, {7'd0, S1, S0}, 1'b0};
    t8[7] = '{10'd5,   1'b0, {7'd0, S0, S5}, 1'b0};
    t8[8] = '{10'd255, 1'b1, {7'd0, SD, SD}, 1'b1};
    t8[9] = '{10'd68,  1'b1, {7'd0, S6, S8}, 1'b0};

    t10[0] = '{10'd1023, 1'b0, {SD, SD, SD}, 1'b1};
    t10[1] = '{10'd305,  1'b0, {S3, S0, S5}, 1'b0};
    t10[2] = '{10'd999,  1'b1, {S9, S9, S9}, 1'b0};
    t10[3] = '{10'd1000, 1'b1, {SD, SD, SD}, 1'b1};
    t10[4] = '{10'd40,   1'b1, {SB, S4, S0}, 1'b0};

    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst10 = 1'b0;
    check("rst_hex8",   {7'd0, i8.HEX}, {7'd0, S0, S0});
    check("rst_busy8",  {20'd0, i8.BUSY}, 21'd0);
    check("rst_ovf8",   {20'd0, i8.OVF}, 21'd0);
    check("rst_hex10",  i10.HEX, {S0, S0, S0});
    check("rst_busy10", {19'd0, i10.BUSY, i10.OVF}, 21'd0);

    for (int i = 0; i < 10; i++) load8(t8[i].v, t8[i].b, t8[i].h, t8[i].o, 1'b1);
    for (int i = 0; i < 5; i++) load10(t10[i].v, t10[i].b, t10[i].h, t10[i].o);
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      model(v, 1'($urandom_range(0, 1)), 2, mh, mo);
      load8(10'(v), 1'(mh[13:7] == SB), mh, mo, 1'b1);
    end
    drain(60);

    // BUSY width and DONE width on a full-scale fit.
    load8(10'd99, 1'b0, {7'd0, S9, S9}, 1'b0, 1'b1);
    busy_n = 1;
    for (int t = 0; t < 20 && !i8.DONE; t++) begin
      @(negedge clk);
      if (i8.BUSY) busy_n++;
    end
    check("busy_width", 21'(busy_n), 21'd8);
    @(negedge clk);
    check("done_width", {20'd0, i8.DONE}, 21'd0);

    // LOAD during a conversion is dropped.
    load8(10'd45, 1'b0, {7'd0, S4, S5}, 1'b0, 1'b1);
    @(negedge clk);
    i8.VALUE = 8'd12; i8.BLANK_LZ = 1'b1; i8.LOAD = 1'b1;
    @(negedge clk);
    i8.LOAD = 1'b0;
    drain(30);
    repeat (12) @(negedge clk);
    check("shown_after_ignored", {7'd0, i8.HEX}, {7'd0, S4, S5});

    // LOAD in the DONE cycle.
    load8(10'd45, 1'b0, {7'd0, S4, S5}, 1'b0, 1'b1);
    for (int t = 0; t < 20 && !i8.DONE; t++) @(negedge clk);
    load8(10'd12, 1'b0, {7'd0, S1, S2}, 1'b0, 1'b1);
    drain(30);

    // Reset in cycle 4 of a conversion discards it and the old display.
    load8(10'd88, 1'b0, 21'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("midrst_hex",  {7'd0, i8.HEX}, {7'd0, S0, S0});
    check("midrst_busy", {19'd0, i8.BUSY, i8.DONE}, 21'd0);
    check("midrst_ovf",  {20'd0, i8.OVF}, 21'd0);
    repeat (14) @(negedge clk);
    check("midrst_hold", {7'd0, i8.HEX}, {7'd0, S0, S0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
